seg7_counter_display: RTL and testbench
=======================================

Name: seg7_counter_display

Overview:
Parametrised up/down modulo counter driving a time-multiplexed 7-segment hex display. It is the next-generation counter-plus-display block and replaces the fixed 3-bit ripple T-flip-flop counter and its display decoder. All state is synchronous to one clock; there are no derived clocks. It sits between board inputs (clock, push-buttons) and the 7-segment display pins.

Parameters:
WIDTH, 3, counter width in bits, legal range 1..16; derived NDIG = (WIDTH+3)/4 digits.
MODULUS, 8, count range 0..MODULUS-1, legal range 2..2**WIDTH.
SCAN_DIV, 1024, clock cycles each digit is displayed, legal minimum 1.
SEG_ACTIVE_LOW, 0, when 1 invert seg, dp and digit_sel at the output registers.
DEBOUNCE_CYCLES, 16, stable-cycle count for the debounce filter; used only with the optional feature.

Ports:
input_clock  in  1  single clock, rising edge.
input_reset_n  in  1  reset; asynchronous, active-low.
count_en  in  1  count enable (push-button).
count_up  in  1  direction: 1 = up, 0 = down.
load  in  1  synchronous load strobe.
load_value  in  WIDTH  value to load.
count  out  WIDTH  current count, registered.
wrap  out  1  one-cycle pulse on modulus wrap.
seg  out  7  segments, bit0 = a through bit6 = g.
dp  out  1  decimal point.
digit_sel  out  NDIG  one-hot digit enable.

Behaviour:
- Reset: count=0, wrap=0, prescaler=0, digit index=0, heartbeat=0. seg, dp and digit_sel are all off (all 0, or all 1 if SEG_ACTIVE_LOW). Reset asserted mid-count or mid-scan takes effect immediately.
- Counter priority per cycle:
  - load: count <= min(load_value, MODULUS-1); wrap=0.
  - else step (count_en=1): up: count==MODULUS-1 gives 0 and wrap=1, otherwise +1. Down: count==0 gives MODULUS-1 and wrap=1, otherwise -1.
  - else hold, wrap=0.
- wrap is registered, high exactly 1 cycle, coincident with the wrapped count value.
- Heartbeat flips on every wrap.
- Scan:
  - prescaler counts 0..SCAN_DIV-1.
  - At terminal count the digit index advances (mod NDIG) and the prescaler returns to 0.
  - With NDIG==1 the index stays 0 and digit_sel stays at 1.
- Display path, registered, 1-cycle latency:
  - nibble = count[4*idx+3 : 4*idx], zero-padded above WIDTH.
  - seg <= hex encoding of the nibble for 0-F, standard shapes, lowercase b and d.
  - digit_sel <= one-hot(idx).
  - dp <= heartbeat when idx==0, else 0.
- Count changes appear on seg one cycle after count updates.
- Width: internal arithmetic is WIDTH bits. MODULUS==2**WIDTH must not overflow the compare constant; use a WIDTH+1-bit constant.

Optional Feature:
SEG7_COUNTER_DEBOUNCE_EN
- Defined:
  - count_en and count_up each pass through a 2-FF synchroniser, then a filter that updates only after DEBOUNCE_CYCLES consecutive identical samples.
  - A step occurs once per rising edge of the filtered count_en, so one press gives one step.
  - Latency from press to count: 2 + DEBOUNCE_CYCLES + 1 cycles.
  - load is not debounced.
- Undefined: count_en is a level enable, stepping every cycle it is high; count_up is used directly; no synchroniser.

Decomposition:
- Package seg7_pkg:
  - 16-entry segment encoding constant (bit0 = a).
  - SEG_OFF constant.
  - function ndig(width).
- Sub-module seg7_hex_decoder: combinational nibble to 7 bits, reused by other display blocks.
- Debounce logic stays inline under the macro.

Test Plan:
1. Reset, defaults, macro off; hold count_en=1, count_up=1 for 10 cycles. Required: count 0..7 then 0,1. wrap high only in the cycle count goes 7 to 0. seg=7'h3F for count 0, one cycle after count.
2. WIDTH=4, MODULUS=10, count_up=0, from reset, step 1 cycle. Required: count=9, wrap=1. Next cycle count=8, wrap=0.
3. MODULUS=10, load=1 with load_value=13, same cycle as count_en=1. Required: count=9, no wrap, no step.
4. WIDTH=8, SCAN_DIV=4. Required: digit_sel 01 for 4 cycles, then 10 for 4 cycles, repeating. With count=8'hA5, seg shows 5 (7'h6D) when digit_sel=01 and A (7'h77) when digit_sel=10.
5. Assert input_reset_n=0 asynchronously mid-count at count=5. Required: count=0 and seg/digit_sel off before the next clock edge. After release, digit 0 shows 0.
6. Macro on, DEBOUNCE_CYCLES=4; count_en bounces 1,0,1 then holds 1 for 20 cycles. Required: exactly one step, count 0 to 1, appearing 7 cycles after the stable 1 starts.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for 7-segment display blocks: hex segment table (bit0 = a)
// and the digit-count helper used to size digit_sel.
package seg7_pkg;

    // Index 15 first; lowercase shapes for b and d.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic int ndig(input int width);
        return (width + 3) / 4;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to 7-segment pattern (bit0 = a, active-high).
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_counter_display.sv
// Up/down modulo counter with a time-multiplexed hex display.
// Optional macro SEG7_COUNTER_DEBOUNCE_EN adds synchronised, debounced edge-triggered stepping.
module seg7_counter_display
    import seg7_pkg::*;
#(
    parameter  int WIDTH           = 3,
    parameter  int MODULUS         = 8,
    parameter  int SCAN_DIV        = 1024,
    parameter  int SEG_ACTIVE_LOW  = 0,
    parameter  int DEBOUNCE_CYCLES = 16,
    localparam int NDIG            = ndig(WIDTH)
) (
    input  logic             input_clock,
    input  logic             input_reset_n,
    input  logic             count_en,
    input  logic             count_up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic [6:0]       seg,
    output logic             dp,
    output logic [NDIG-1:0]  digit_sel
);

    // One extra bit so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   MAX_W = MOD_W - (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MAX   = MAX_W[WIDTH-1:0];
    localparam int               PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int               IW    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic             POL   = (SEG_ACTIVE_LOW != 0);

    logic step_en;
    logic dir_up;

`ifdef SEG7_COUNTER_DEBOUNCE_EN
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // Channel 0 = count_en, channel 1 = count_up.
    logic [1:0]          raw, sync_a, sync_b, filt;
    logic [1:0][DBW-1:0] stable_cnt;
    logic                en_filt_d;

    assign raw = {count_up, count_en};

    always_ff @(posedge input_clock or negedge input_reset_n) begin
        if (!input_reset_n) begin
            sync_a     <= '0;
            sync_b     <= '0;
            filt       <= '0;
            stable_cnt <= '0;
            en_filt_d  <= 1'b0;
        end else begin
            sync_a    <= raw;
            sync_b    <= sync_a;
            en_filt_d <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == filt[i]) begin
                    stable_cnt[i] <= '0;
                end else if (stable_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    filt[i]       <= sync_b[i];
                    stable_cnt[i] <= '0;
                end else begin
                    stable_cnt[i] <= stable_cnt[i] + DBW'(1);
                end
            end
        end
    end

    assign step_en = filt[0] & ~en_filt_d;
    assign dir_up  = filt[1];
`else
    logic unused_debounce;

    assign step_en         = count_en;
    assign dir_up          = count_up;
    assign unused_debounce = |DEBOUNCE_CYCLES;
`endif

    logic [WIDTH-1:0] count_next;
    logic             wrap_next;
    logic             heartbeat;

    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        if (load) begin
            count_next = ({1'b0, load_value} > MAX_W) ? MAX : load_value;
        end else if (step_en) begin
            if (dir_up) begin
                if (count == MAX) begin
                    count_next = '0;
                    wrap_next  = 1'b1;
                end else begin
                    count_next = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    count_next = MAX;
                    wrap_next  = 1'b1;
                end else begin
                    count_next = count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge input_clock or negedge input_reset_n) begin
        if (!input_reset_n) begin
            count     <= '0;
            wrap      <= 1'b0;
            heartbeat <= 1'b0;
        end else begin
            count     <= count_next;
            wrap      <= wrap_next;
            heartbeat <= heartbeat ^ wrap_next;
        end
    end

    logic [PW-1:0] prescaler;
    logic [IW-1:0] idx;

    always_ff @(posedge input_clock or negedge input_reset_n) begin
        if (!input_reset_n) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (prescaler == PW'(SCAN_DIV - 1)) begin
            prescaler <= '0;
            idx       <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Nibble select and one-hot digit from the current scan index.
    logic [4*NDIG-1:0] padded;
    logic [3:0]        nibble;
    logic [NDIG-1:0]   sel_next;
    logic [6:0]        hex_seg;

    assign padded = (4*NDIG)'(count);

    always_comb begin
        nibble   = 4'h0;
        sel_next = '0;
        for (int d = 0; d < NDIG; d++) begin
            if (idx == IW'(d)) begin
                nibble      = padded[4*d +: 4];
                sel_next[d] = 1'b1;
            end
        end
    end

    seg7_hex_decoder u_hex_decoder (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    always_ff @(posedge input_clock or negedge input_reset_n) begin
        if (!input_reset_n) begin
            seg       <= SEG_OFF ^ {7{POL}};
            dp        <= POL;
            digit_sel <= {NDIG{POL}};
        end else begin
            seg       <= hex_seg ^ {7{POL}};
            dp        <= ((idx == '0) ? heartbeat : 1'b0) ^ POL;
            digit_sel <= sel_next ^ {NDIG{POL}};
        end
    end

endmodule

// File: tb/tb_seg7_counter_display.sv
// Directed scoreboard bench for seg7_counter_display: three parameterisations share one clock/reset.
module tb_seg7_counter_display;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // A: defaults (WIDTH 3, MODULUS 8); B: WIDTH 4, MODULUS 10; C: WIDTH 8, MODULUS 256, SCAN_DIV 4.
    logic       en_a, up_a, ld_a, wrap_a, dp_a;
    logic [2:0] lv_a, count_a;
    logic [6:0] seg_a;
    logic [0:0] sel_a;
    logic       en_b, up_b, ld_b, wrap_b, dp_b;
    logic [3:0] lv_b, count_b;
    logic [6:0] seg_b;
    logic [0:0] sel_b;
    logic       en_c, up_c, ld_c, wrap_c, dp_c;
    logic [7:0] lv_c, count_c;
    logic [6:0] seg_c;
    logic [1:0] sel_c;

    seg7_counter_display #(.WIDTH(3), .MODULUS(8), .SCAN_DIV(1024), .SEG_ACTIVE_LOW(0), .DEBOUNCE_CYCLES(4)) dut_a (
        .input_clock(clk), .input_reset_n(rst_n), .count_en(en_a), .count_up(up_a), .load(ld_a),
        .load_value(lv_a), .count(count_a), .wrap(wrap_a), .seg(seg_a), .dp(dp_a), .digit_sel(sel_a));

    seg7_counter_display #(.WIDTH(4), .MODULUS(10)) dut_b (
        .input_clock(clk), .input_reset_n(rst_n), .count_en(en_b), .count_up(up_b), .load(ld_b),
        .load_value(lv_b), .count(count_b), .wrap(wrap_b), .seg(seg_b), .dp(dp_b), .digit_sel(sel_b));

    seg7_counter_display #(.WIDTH(8), .MODULUS(256), .SCAN_DIV(4)) dut_c (
        .input_clock(clk), .input_reset_n(rst_n), .count_en(en_c), .count_up(up_c), .load(ld_c),
        .load_value(lv_c), .count(count_c), .wrap(wrap_c), .seg(seg_c), .dp(dp_c), .digit_sel(sel_c));

    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t  sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   ma, mb, mc, pre_c, idx_c;
    logic hb_a, hb_b, hb_c;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] obs_of(input string tag);
        case (tag)
            "a.count": return 32'(count_a);
            "a.wrap":  return 32'(wrap_a);
            "a.seg":   return 32'(seg_a);
            "a.dp":    return 32'(dp_a);
            "a.sel":   return 32'(sel_a);
            "b.count": return 32'(count_b);
            "b.wrap":  return 32'(wrap_b);
            "b.seg":   return 32'(seg_b);
            "b.dp":    return 32'(dp_b);
            "b.sel":   return 32'(sel_b);
            "c.count": return 32'(count_c);
            "c.wrap":  return 32'(wrap_c);
            "c.seg":   return 32'(seg_c);
            "c.dp":    return 32'(dp_c);
            "c.sel":   return 32'(sel_c);
            default:   return 'x;
        endcase
    endfunction

    function automatic void model_step(input int cur, input int modu, input logic en, input logic up,
                                       input logic ld, input int lv, output int nxt, output logic wr);
        nxt = cur;
        wr  = 1'b0;
        if (ld) begin
            nxt = (lv > modu - 1) ? modu - 1 : lv;
        end else if (en) begin
            if (up) begin
                if (cur == modu - 1) begin nxt = 0; wr = 1'b1; end
                else nxt = cur + 1;
            end else begin
                if (cur == 0) begin nxt = modu - 1; wr = 1'b1; end
                else nxt = cur - 1;
            end
        end
    endfunction

    task automatic reset_models();
        ma = 0; mb = 0; mc = 0; pre_c = 0; idx_c = 0;
        hb_a = 1'b0; hb_b = 1'b0; hb_c = 1'b0;
    endtask

    task automatic drain();
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, obs_of(e.tag), e.exp);
        end
    endtask

    // Push what every DUT must show after the coming edge, then clock and compare.
    task automatic tick();
        int   na, nb, nc, nib;
        logic wa, wb, wc;
        model_step(ma, 8,   en_a, up_a, ld_a, int'(lv_a), na, wa);
        model_step(mb, 10,  en_b, up_b, ld_b, int'(lv_b), nb, wb);
        model_step(mc, 256, en_c, up_c, ld_c, int'(lv_c), nc, wc);
        nib = (idx_c == 1) ? (mc >> 4) : (mc & 15);
        push("a.count", 32'(na)); push("a.wrap", 32'(wa)); push("a.seg", 32'(HEX[ma]));
        push("a.dp", 32'(hb_a));  push("a.sel", 32'd1);
        push("b.count", 32'(nb)); push("b.wrap", 32'(wb)); push("b.seg", 32'(HEX[mb]));
        push("b.dp", 32'(hb_b));  push("b.sel", 32'd1);
        push("c.count", 32'(nc)); push("c.wrap", 32'(wc)); push("c.seg", 32'(HEX[nib]));
        push("c.dp", (idx_c == 0) ? 32'(hb_c) : 32'd0);
        push("c.sel", (idx_c == 1) ? 32'd2 : 32'd1);
        ma = na; hb_a ^= wa;
        mb = nb; hb_b ^= wb;
        mc = nc; hb_c ^= wc;
        if (pre_c == 3) begin pre_c = 0; idx_c ^= 1; end
        else pre_c++;
        @(posedge clk); #1;
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        en_a = 0; up_a = 1; ld_a = 0; lv_a = '0;
        en_b = 0; up_b = 0; ld_b = 0; lv_b = '0;
        en_c = 0; up_c = 0; ld_c = 0; lv_c = '0;
        reset_models();
        repeat (3) @(posedge clk);
        #1;
        check("rst.count_a", 32'(count_a), 32'd0);
        check("rst.wrap_a",  32'(wrap_a),  32'd0);
        check("rst.seg_a",   32'(seg_a),   32'd0);
        check("rst.dp_a",    32'(dp_a),    32'd0);
        check("rst.sel_a",   32'(sel_a),   32'd0);
        check("rst.seg_c",   32'(seg_c),   32'd0);
        check("rst.sel_c",   32'(sel_c),   32'd0);
        rst_n = 1'b1;

`ifndef SEG7_COUNTER_DEBOUNCE_EN
        // A counts up continuously; B steps down from reset twice; C shows 8'hA5 while scanning.
        for (int i = 0; i < 18; i++) begin
            en_a = (i < 10); up_a = 1'b1;
            en_b = (i < 2);  up_b = 1'b0;
            ld_c = (i == 0); lv_c = 8'hA5;
            tick();
            if (i == 0) begin
                check("t2.count9", 32'(count_b), 32'd9);
                check("t2.wrap1",  32'(wrap_b),  32'd1);
            end
            if (i == 1) begin
                check("t2.count8", 32'(count_b), 32'd8);
                check("t2.wrap0",  32'(wrap_b),  32'd0);
            end
            if (i >= 1 && sel_c == 2'b01) check("t4.seg5", 32'(seg_c), 32'h6D);
            if (i >= 1 && sel_c == 2'b10) check("t4.segA", 32'(seg_c), 32'h77);
        end
        ld_c = 1'b0;

        // Load beats step and clamps to MODULUS-1; then wrap up from the top value.
        en_b = 1; up_b = 1; ld_b = 1; lv_b = 4'd13;
        tick();
        check("t3.clamp",  32'(count_b), 32'd9);
        check("t3.nowrap", 32'(wrap_b),  32'd0);
        ld_b = 0;
        tick();
        ld_b = 1; lv_b = 4'd3; en_b = 0;
        ld_c = 1; lv_c = 8'hFF;
        tick();
        ld_b = 0; ld_c = 0; en_c = 1; up_c = 1;
        tick();
        up_c = 0;
        tick();
        en_c = 0;

        // Bring A to 5, then pull reset between edges.
        en_a = 1;
        repeat (3) tick();
        check("t5.pre", 32'(count_a), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5.count0", 32'(count_a), 32'd0);
        check("t5.wrap0",  32'(wrap_a),  32'd0);
        check("t5.segoff", 32'(seg_a),   32'd0);
        check("t5.seloff", 32'(sel_a),   32'd0);
        check("t5.c_off",  32'(sel_c),   32'd0);
        en_a = 0;
        #1;
        rst_n = 1'b1;
        reset_models();
        tick();
        check("t5.seg0", 32'(seg_a), 32'h3F);
        check("t5.sel1", 32'(sel_a), 32'd1);
`else
        // Let the count_up filter settle, then bounce count_en and hold it high.
        en_a = 0; up_a = 1;
        repeat (10) @(posedge clk);
        #1;
        en_a = 1;
        @(posedge clk); #1;
        en_a = 0;
        @(posedge clk); #1;
        en_a = 1;
        for (int k = 1; k <= 20; k++) begin
            push("a.count", (k >= 7) ? 32'd1 : 32'd0);
            push("a.wrap", 32'd0);
            @(posedge clk); #1;
            drain();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
